seg_frame_scheduler: RTL and testbench

Ping-pong frame-buffer scheduler between the segmentation engine, which writes one 8-bit class ID per pixel in raster order, and `result_display`, which fetches class IDs by `pixel_addr`. It owns a single-port synchronous RAM split into two banks of IMAGE_WIDTH×IMAGE_HEIGHT entries. It arbitrates the one RAM port, with the reader having fixed priority. It swaps front and back banks only at display frame boundaries, so the display never shows a partially written class map.

---
 rtl/seg_frame_scheduler.sv | 162 ++++++++++++++++
 tb/tb_seg_frame_scheduler.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_frame_scheduler.sv
// seg_frame_scheduler: ping-pong frame-buffer scheduler.
//
// The segmentation engine writes class IDs in raster order into the back bank.
// result_display reads the front bank. Both share one single-port synchronous RAM.
// The reader always wins the RAM port.
// Banks swap only at a display frame boundary, or immediately for the very first frame.
// Because of this, the display never shows a partially written class map.
module seg_frame_scheduler #(
  parameter int IMAGE_WIDTH  = 320,
  parameter int IMAGE_HEIGHT = 240,
  parameter int ADDR_WIDTH   = 20
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  wr_req,
  input  logic [7:0]            wr_data,
  output logic                  wr_gnt,
  input  logic                  rd_req,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic                  rd_valid,
  output logic [7:0]            rd_data,
  input  logic                  rd_frame_start,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata,
  output logic                  front_bank,
  output logic                  frame_ready,
  output logic                  done,
  output logic [7:0]            frame_cnt
);

  localparam int NPIX = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_WIDTH-1:0] NPIX_A = ADDR_WIDTH'(NPIX);
  localparam logic [ADDR_WIDTH-1:0] LAST_A = ADDR_WIDTH'(NPIX - 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    FILL      = 2'd1,
    WAIT_SWAP = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic                  front_bank_q, front_bank_d;
  logic                  frame_ready_q, frame_ready_d;
  logic                  done_q, done_d;
  logic [7:0]            frame_cnt_q, frame_cnt_d;
  logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
  logic                  rd_valid_q, rd_valid_d;
  // Set when last cycle's read really touched the RAM, so mem_rdata is meaningful now.
  logic                  rd_hit_q, rd_hit_d;

  logic                  rd_ok;
  logic                  wr_fire;
  logic [ADDR_WIDTH-1:0] front_base;
  logic [ADDR_WIDTH-1:0] back_base;

  // RAM port arbitration: a read always wins, and a write goes only when no read is asking.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first, so no latch is inferred.
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = wr_data;
    front_base = front_bank_q ? NPIX_A : '0;
    back_base  = front_bank_q ? '0 : NPIX_A;
    // Reads of an empty front bank or past the frame end skip the RAM and return zero.
    rd_ok      = rd_req && frame_ready_q && (rd_addr < NPIX_A);
    wr_gnt     = (state_q == FILL) && !rd_req;
    wr_fire    = wr_req && wr_gnt;
    if (rd_req) begin
      mem_en   = rd_ok;
      mem_addr = front_base + rd_addr;
    end else if (wr_fire) begin
      mem_en   = 1'b1;
      mem_we   = 1'b1;
      mem_addr = back_base + wr_cnt_q;
    end
  end

  // Next-state logic: fill the back bank, then swap at the first frame end or at the next vsync.
  always_comb begin
    state_d       = state_q;
    front_bank_d  = front_bank_q;
    frame_ready_d = frame_ready_q;
    done_d        = 1'b0;
    frame_cnt_d   = frame_cnt_q;
    wr_cnt_d      = wr_cnt_q;
    rd_valid_d    = rd_req;
    rd_hit_d      = rd_ok;

    unique case (state_q)
      IDLE: begin
        if (start) state_d = FILL;
      end
      FILL: begin
        if (wr_fire) begin
          if (wr_cnt_q == LAST_A) begin
            if (!frame_ready_q) begin
              state_d       = FILL;
              front_bank_d  = !front_bank_q;
              frame_ready_d = 1'b1;
              done_d        = 1'b1;
              frame_cnt_d   = frame_cnt_q + 8'd1;
              wr_cnt_d      = '0;
            end else begin
              state_d = WAIT_SWAP;
            end
          end else begin
            wr_cnt_d = wr_cnt_q + 1'b1;
          end
        end
      end
      WAIT_SWAP: begin
        if (rd_frame_start) begin
          state_d       = FILL;
          front_bank_d  = !front_bank_q;
          frame_ready_d = 1'b1;
          done_d        = 1'b1;
          frame_cnt_d   = frame_cnt_q + 8'd1;
          wr_cnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset; reset discards any partial frame.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      front_bank_q  <= 1'b0;
      frame_ready_q <= 1'b0;
      done_q        <= 1'b0;
      frame_cnt_q   <= 8'd0;
      wr_cnt_q      <= '0;
      rd_valid_q    <= 1'b0;
      rd_hit_q      <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      state_q       <= state_d;
      front_bank_q  <= front_bank_d;
      frame_ready_q <= frame_ready_d;
      done_q        <= done_d;
      frame_cnt_q   <= frame_cnt_d;
      wr_cnt_q      <= wr_cnt_d;
      rd_valid_q    <= rd_valid_d;
      rd_hit_q      <= rd_hit_d;
    end
  end

  assign front_bank  = front_bank_q;
  assign frame_ready = frame_ready_q;
  assign done        = done_q;
  assign frame_cnt   = frame_cnt_q;
  assign rd_valid    = rd_valid_q;
  // The RAM output register supplies the read data; it is forced to zero unless a real access happened.
  assign rd_data     = rd_hit_q ? mem_rdata : 8'd0;

endmodule

// File: tb/tb_seg_frame_scheduler.sv
// Testbench for seg_frame_scheduler with a 4x4 frame (NPIX=16) and a behavioural 1-cycle RAM.
// Expected read data goes into a scoreboard queue when the read is issued.
// A monitor pops the queue and compares whenever rd_valid is high.
module tb_seg_frame_scheduler;

  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          wr_req;
  logic [7:0]    wr_data;
  logic          wr_gnt;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_valid;
  logic [7:0]    rd_data;
  logic          rd_frame_start;
  logic          mem_en;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic [7:0]    mem_rdata;
  logic          front_bank;
  logic          frame_ready;
  logic          done;
  logic [7:0]    frame_cnt;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] sb_q[$];
  logic [7:0] ram[32];

  seg_frame_scheduler #(.IMAGE_WIDTH(4), .IMAGE_HEIGHT(4), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .wr_req(wr_req), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_valid(rd_valid), .rd_data(rd_data),
    .rd_frame_start(rd_frame_start),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .front_bank(front_bank), .frame_ready(frame_ready), .done(done), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Single-port synchronous RAM with 1-cycle read latency.
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata     <= ram[mem_addr];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let the combinational outputs settle after the inputs change, staying well before the next edge.
  task automatic settle();
    #2;
  endtask

  // Present one write beat that is expected to be granted, then check the RAM write it produces.
  task automatic beat(input logic [7:0] d, input logic [AW-1:0] exp_addr);
    wr_req  = 1'b1;
    wr_data = d;
    settle();
    check("beat_gnt", wr_gnt, 1);
    check("beat_we", {mem_en, mem_we}, 2'b11);
    check("beat_addr", mem_addr, exp_addr);
    tick();
    wr_req = 1'b0;
  endtask

  // Issue a single-cycle read and push the expected rd_data into the scoreboard.
  task automatic read(input logic [AW-1:0] a, input logic [7:0] exp_d,
                      input logic exp_en, input logic [AW-1:0] exp_addr, input string name);
    rd_req  = 1'b1;
    rd_addr = a;
    settle();
    check({name, "_en"}, mem_en, exp_en);
    if (exp_en) check({name, "_addr"}, mem_addr, exp_addr);
    sb_q.push_back(exp_d);
    tick();
    rd_req = 1'b0;
  endtask

  // Monitor: whenever a read result is presented, pop the scoreboard and compare.
  initial begin
    forever begin
      @(negedge clk);
      if (rd_valid === 1'b1) begin
        if (sb_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL rd_unexpected: got rd_valid=1 data=%0d, required no read result", rd_data);
        end else begin
          check("rd_data", rd_data, sb_q.pop_front());
        end
      end
    end
  end

  // Watchdog so the bench always terminates.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required normal end");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; wr_req = 1'b1; wr_data = 8'd0;
    rd_req = 1'b1; rd_addr = '0; rd_frame_start = 1'b0;
    tick();
    tick();
    settle();
    check("rst_wr_gnt", wr_gnt, 0);
    check("rst_mem_en", mem_en, 0);
    check("rst_front", front_bank, 0);
    check("rst_ready", frame_ready, 0);
    check("rst_done", done, 0);
    check("rst_cnt", frame_cnt, 0);
    check("rst_rd_valid", rd_valid, 0);
    rst_n = 1'b1; wr_req = 1'b0; rd_req = 1'b0;
    tick();

    // A read before any frame is complete returns zero without touching the RAM.
    read(5'd2, 8'd0, 1'b0, '0, "guard_pre");
    check("idle_gnt", wr_gnt, 0);

    start = 1'b1;
    tick();
    start = 1'b0;

    // First frame: 0..15 go into back bank 1 (addresses 16..31), then swap immediately.
    for (int i = 0; i < 16; i++) beat(8'(i), 5'(16 + i));
    settle();
    check("f1_front", front_bank, 1);
    check("f1_ready", frame_ready, 1);
    check("f1_done", done, 1);
    check("f1_cnt", frame_cnt, 1);
    tick();
    check("f1_done_clr", done, 0);

    read(5'd5, 8'd5, 1'b1, 5'd21, "f1_rd5");
    read(5'd16, 8'd0, 1'b0, '0, "guard_oob");

    // Contention: the read wins and the write beat waits one cycle.
    wr_req = 1'b1; wr_data = 8'd100; rd_req = 1'b1; rd_addr = 5'd3;
    settle();
    check("cont_gnt", wr_gnt, 0);
    check("cont_we", mem_we, 0);
    check("cont_addr", mem_addr, 19);
    sb_q.push_back(8'd3);
    tick();
    rd_req = 1'b0;
    beat(8'd100, 5'd0);

    // Second frame goes into bank 0. A vsync coincident with the last beat is ignored.
    for (int i = 1; i < 15; i++) beat(8'(100 + i), 5'(i));
    rd_frame_start = 1'b1;
    beat(8'd115, 5'd15);
    rd_frame_start = 1'b0;
    wr_req = 1'b1; wr_data = 8'd200;
    settle();
    check("ws_gnt", wr_gnt, 0);
    check("ws_mem_en", mem_en, 0);
    check("ws_front", front_bank, 1);
    check("ws_cnt", frame_cnt, 1);
    tick();
    tick();
    check("ws_gnt_hold", wr_gnt, 0);
    check("ws_no_swap", front_bank, 1);
    read(5'd3, 8'd3, 1'b1, 5'd19, "ws_rd3");

    // Swap cycle: a read in that cycle still uses the old front bank.
    rd_frame_start = 1'b1;
    wr_req = 1'b0;
    read(5'd3, 8'd3, 1'b1, 5'd19, "swap_rd3");
    rd_frame_start = 1'b0;
    settle();
    check("f2_front", front_bank, 0);
    check("f2_done", done, 1);
    check("f2_cnt", frame_cnt, 2);
    read(5'd3, 8'd103, 1'b1, 5'd3, "f2_rd3");
    check("f2_done_clr", done, 0);

    // Mid-fill reset after 7 beats of the next frame, written to bank 1.
    for (int i = 0; i < 7; i++) beat(8'(50 + i), 5'(16 + i));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    wr_req = 1'b1;
    settle();
    check("mrst_front", front_bank, 0);
    check("mrst_ready", frame_ready, 0);
    check("mrst_cnt", frame_cnt, 0);
    check("mrst_gnt", wr_gnt, 0);
    tick();
    tick();
    check("mrst_gnt_hold", wr_gnt, 0);
    wr_req = 1'b0;
    read(5'd3, 8'd0, 1'b0, '0, "mrst_rd");
    start = 1'b1;
    tick();
    start = 1'b0;
    settle();
    check("restart_gnt", wr_gnt, 1);

    tick();
    tick();
    check("sb_empty", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
